// File: rtl/fft_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl_if
// Streaming bus used on both sides of fft_frame_ctrl.
//   data  : sample / word payload
//   valid : payload valid
//   last  : final word of a frame (qualified by valid)
//   ready : sink accepts the word
// The master drives data/valid/last; the slave drives ready.
// ---------------------------------------------------------------------------
interface fft_frame_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  last;
   logic                  ready;

   modport master (output data, valid, last, input  ready);
   modport slave  (input  data, valid, last, output ready);
endinterface

// File: rtl/fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl
// Sequencer for the FFT spectrum RAM: captures one aligned FFT frame through
// the RAM write port, holds it, and streams it to the display through the RAM
// read port. A capture can never start while a readout is in progress.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   arm             : pulse, request capture of the next complete frame
//   s_if (slave)    : FFT sample stream (ready tied high, no backpressure)
//   disp_start      : pulse, request readout of the stored frame
//   m_if (master)   : display stream, registered outputs
//   ram_wr_*        : RAM write port (registered)
//   ram_rd_addr     : RAM read address; ram_rd_data is valid one cycle later
//   frame_done/err  : single-cycle status pulses
//   frame_valid     : RAM holds a complete frame
//   state           : current FSM state for debug
// ---------------------------------------------------------------------------
module fft_frame_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int FRAME_LEN  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   fft_frame_ctrl_if.slave       s_if,
   input  logic                  disp_start,
   fft_frame_ctrl_if.master      m_if,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic                  frame_valid,
   output logic [2:0]            state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SYNC    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_READY   = 3'd3,
      ST_READOUT = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] WCNT_LAST = ADDR_WIDTH'(FRAME_LEN - 1);
   localparam logic [ADDR_WIDTH:0]   RD_END    = (ADDR_WIDTH + 1)'(FRAME_LEN);
   localparam logic [ADDR_WIDTH:0]   RD_LAST   = (ADDR_WIDTH + 1)'(FRAME_LEN - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
   logic                  arm_pend_q, arm_pend_d;
   logic                  frame_valid_q, frame_valid_d;
   logic                  frame_done_q, frame_done_d;
   logic                  frame_err_q, frame_err_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   // One extra bit so the read counter reaches FRAME_LEN instead of wrapping.
   logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
   logic                  rd_vld_q, rd_vld_d;
   logic                  rd_last_q, rd_last_d;
   logic                  m_valid_q, m_valid_d;
   logic                  m_last_q, m_last_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic                  sk_valid_q, sk_valid_d;
   logic                  sk_last_q, sk_last_d;
   logic [DATA_WIDTH-1:0] sk_data_q, sk_data_d;

   logic                  pop;
   logic                  rd_issue;
   logic [2:0]            credit;

   assign pop = m_valid_q & m_if.ready;

   // Words that will still occupy the buffer after this cycle's pop, counting
   // the read whose data is on ram_rd_data now. A new read is only launched
   // when that leaves room, which keeps the 2-entry buffer from overflowing
   // while still allowing one word per cycle with m_ready held high.
   assign credit = 3'(m_valid_q) + 3'(sk_valid_q) + 3'(rd_vld_q) - 3'(pop);

   // ---------------- FSM register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM next state / capture / read issue ----------------
   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      arm_pend_d    = arm_pend_q;
      frame_valid_d = frame_valid_q;
      frame_done_d  = 1'b0;
      frame_err_d   = 1'b0;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      rd_cnt_d      = rd_cnt_q;
      rd_issue      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arm) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (s_if.valid && s_if.last) begin
               state_d = ST_CAPTURE;
               wcnt_d  = '0;
            end
         end
         ST_CAPTURE: begin
            if (s_if.valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = wcnt_q;
               wr_data_d = s_if.data;
               if (wcnt_q == WCNT_LAST) begin
                  wcnt_d = '0;
                  if (s_if.last) begin
                     state_d       = ST_READY;
                     frame_done_d  = 1'b1;
                     frame_valid_d = 1'b1;
                  end else begin
                     // Frame ran past its length: resynchronise.
                     state_d     = ST_SYNC;
                     frame_err_d = 1'b1;
                  end
               end else if (s_if.last) begin
                  // Early end: the following beat is the start of a new frame.
                  wcnt_d      = '0;
                  frame_err_d = 1'b1;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         ST_READY: begin
            if (arm_pend_q) begin
               state_d    = ST_SYNC;
               arm_pend_d = 1'b0;
            end else if (disp_start) begin
               state_d    = ST_READOUT;
               rd_cnt_d   = '0;
               arm_pend_d = arm;
            end else if (arm) begin
               state_d = ST_SYNC;
            end
         end
         ST_READOUT: begin
            if (arm) arm_pend_d = 1'b1;
            if ((rd_cnt_q != RD_END) && (credit < 3'd2)) begin
               rd_issue = 1'b1;
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
            if (pop && m_last_q) state_d = ST_READY;
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_d == ST_SYNC) && (state_q != ST_SYNC)) frame_valid_d = 1'b0;
   end

   // ---------------- read return / skid buffer ----------------
   always_comb begin
      rd_vld_d   = rd_issue;
      rd_last_d  = rd_issue && (rd_cnt_q == RD_LAST);
      m_valid_d  = m_valid_q;
      m_last_d   = m_last_q;
      m_data_d   = m_data_q;
      sk_valid_d = sk_valid_q;
      sk_last_d  = sk_last_q;
      sk_data_d  = sk_data_q;

      if (!m_valid_q || pop) begin
         // Output slot frees up: oldest word (skid first) moves forward.
         if (sk_valid_q) begin
            m_valid_d  = 1'b1;
            m_last_d   = sk_last_q;
            m_data_d   = sk_data_q;
            sk_valid_d = rd_vld_q;
            sk_last_d  = rd_last_q;
            sk_data_d  = ram_rd_data;
         end else if (rd_vld_q) begin
            m_valid_d  = 1'b1;
            m_last_d   = rd_last_q;
            m_data_d   = ram_rd_data;
         end else begin
            m_valid_d  = 1'b0;
            m_last_d   = 1'b0;
         end
      end else if (rd_vld_q) begin
         // Output stalled: returning word parks in the skid entry.
         sk_valid_d = 1'b1;
         sk_last_d  = rd_last_q;
         sk_data_d  = ram_rd_data;
      end
   end

   // ---------------- datapath / control registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q        <= '0;
         arm_pend_q    <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         rd_cnt_q      <= '0;
         rd_vld_q      <= 1'b0;
         rd_last_q     <= 1'b0;
         m_valid_q     <= 1'b0;
         m_last_q      <= 1'b0;
         m_data_q      <= '0;
         sk_valid_q    <= 1'b0;
         sk_last_q     <= 1'b0;
      end else begin
         wcnt_q        <= wcnt_d;
         arm_pend_q    <= arm_pend_d;
         frame_valid_q <= frame_valid_d;
         frame_done_q  <= frame_done_d;
         frame_err_q   <= frame_err_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         rd_cnt_q      <= rd_cnt_d;
         rd_vld_q      <= rd_vld_d;
         rd_last_q     <= rd_last_d;
         m_valid_q     <= m_valid_d;
         m_last_q      <= m_last_d;
         m_data_q      <= m_data_d;
         sk_valid_q    <= sk_valid_d;
         sk_last_q     <= sk_last_d;
      end
   end

   // Skid payload is qualified by sk_valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      sk_data_q <= sk_data_d;
   end

   assign s_if.ready  = 1'b1;
   assign m_if.data   = m_data_q;
   assign m_if.valid  = m_valid_q;
   assign m_if.last   = m_last_q;
   assign ram_wr_en   = wr_en_q;
   assign ram_wr_addr = wr_addr_q;
   assign ram_wr_data = wr_data_q;
   assign ram_rd_addr = rd_cnt_q[ADDR_WIDTH-1:0];
   assign frame_done  = frame_done_q;
   assign frame_err   = frame_err_q;
   assign frame_valid = frame_valid_q;
   assign state       = state_q;

endmodule
